// File: rtl/coin_input_conditioner.sv
// rtl/coin_input_conditioner.sv - synchronize, debounce and serialize coin/cancel events into one-cycle codes
module coin_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
    input  logic       cancel_raw,
    output logic [2:0] code,
    output logic       code_valid,
    output logic       overrun
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    GAP_LOAD = 4'(GAP_CYCLES);

    localparam logic [2:0] CODE_IDLE   = 3'b000;
    localparam logic [2:0] CODE_COIN5  = 3'b001;
    localparam logic [2:0] CODE_COIN10 = 3'b010;
    localparam logic [2:0] CODE_CANCEL = 3'b101;

    // Channel index: 0 = coin5, 1 = coin10, 2 = cancel (also the priority order, high index wins).
    logic [2:0]    raw;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    stb;
    logic [2:0]    pend;
    logic [CW-1:0] cnt [3];
    logic [2:0]    mismatch;
    logic [2:0]    settle;
    logic [2:0]    event_hit;
    logic [2:0]    clear;
    logic [2:0]    next_code;
    logic          emit;
    logic [3:0]    gap_cnt;

    assign raw = {cancel_raw, coin10_raw, coin5_raw};

    // Debounce decisions per channel. The sample counted on an edge is the value being
    // clocked out of the first synchronizer stage, so a change is counted on the edge it
    // enters s2 and a level is accepted after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        mismatch  = '0;
        settle    = '0;
        event_hit = '0;
        for (int i = 0; i < 3; i++) begin
            mismatch[i]  = (s1[i] != stb[i]);
            settle[i]    = mismatch[i] && (cnt[i] == CNT_LAST);
            event_hit[i] = settle[i] && s1[i];
        end
    end

    // Priority select of the pending event to emit: cancel, then coin10, then coin5.
    always_comb begin
        emit      = (gap_cnt == 4'd0) && (code == CODE_IDLE) && (pend != 3'b000);
        clear     = 3'b000;
        next_code = CODE_IDLE;
        if (emit) begin
            if (pend[2]) begin
                clear     = 3'b100;
                next_code = CODE_CANCEL;
            end else if (pend[1]) begin
                clear     = 3'b010;
                next_code = CODE_COIN10;
            end else begin
                clear     = 3'b001;
                next_code = CODE_COIN5;
            end
        end
    end

    // Synchronizers, stable levels, debounce counters, pending bits and the sticky overrun flag.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s1      <= '0;
            s2      <= '0;
            stb     <= '0;
            pend    <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < 3; i++) begin
                if (settle[i]) begin
                    stb[i] <= s1[i];
                    cnt[i] <= '0;
                end else if (mismatch[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else begin
                    cnt[i] <= '0;
                end
                // A new event beats a same-edge clear; only a genuinely held pend loses it.
                if (event_hit[i]) begin
                    pend[i] <= 1'b1;
                    if (pend[i] && !clear[i]) begin
                        overrun <= 1'b1;
                    end
                end else if (clear[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Output code register and inter-code gap counter.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            code       <= CODE_IDLE;
            code_valid <= 1'b0;
            gap_cnt    <= 4'd0;
        end else begin
            code       <= next_code;
            code_valid <= emit;
            if (emit) begin
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

endmodule

// File: doc/coin_input_conditioner.md
# coin_input_conditioner

- Front end of the vending datapath, sitting directly upstream of the vending FSM.
- Inputs: three raw, asynchronous, bouncing lines:
  - 5-unit coin sensor.
  - 10-unit coin sensor.
  - Cancel button.
- For each line it synchronizes, debounces and edge-detects the signal. Events are serialized by priority into single-cycle codes on a 3-bit bus that feeds the FSM's `in` input directly.
- Between codes it guarantees idle (000) cycles, so the FSM sees each event exactly once.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples needed to accept a level change; range 1..255.
- GAP_CYCLES, 2: minimum number of 000 cycles inserted after every emitted code; range 0..15.
- clk  input  1  single system clock, rising edge.
- arst  input  1  asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- coin5_raw  input  1  raw 5-unit coin sensor, active high, asynchronous.
- coin10_raw  input  1  raw 10-unit coin sensor, active high, asynchronous.
- cancel_raw  input  1  raw cancel/return button, active high, asynchronous.
- code  output  3  event code, registered: 3'b001 = 5-unit coin, 3'b010 = 10-unit coin, 3'b101 = cancel, 3'b000 = no event.
- code_valid  output  1  registered; high exactly when code != 000.
- overrun  output  1  sticky flag; set when an event is lost, cleared only by arst.

## Operation
- **Per channel, identical logic:**
  - 2-flop synchronizer (s1, s2).
  - Stable-level register `stb`.
  - Debounce counter of width clog2(DEBOUNCE_CYCLES+1).
  - Pending bit `pend`.
- **Debounce:**
  - If s2 == stb, the counter clears.
  - If s2 != stb, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and s2 still != stb:
    - stb <= s2 and the counter clears.
    - If the transition is 0->1, an event is raised on the same edge.
  - 1->0 transitions update stb silently.
  - Glitches shorter than DEBOUNCE_CYCLES samples never change stb.
- **Pending:**
  - An event sets pend.
  - If pend is already 1 and not being cleared on that edge, the event is discarded and overrun <= 1.
  - If an event arrives on the same edge that pend is cleared by emission, pend stays 1. The set wins and no overrun is flagged.
- **Scheduler:**
  - Emission happens at an edge where gap_cnt == 0, code == 000, and at least one pend is set.
  - Priority: cancel > coin10 > coin5.
  - On emission: code <= the selected code, that pend clears, gap_cnt <= GAP_CYCLES.
  - The following edge always returns code to 000.
  - gap_cnt decrements on every edge while it is nonzero.
- Coins are never merged or dropped by the scheduler; only a second event on the same channel while that channel is pending is lost.
- **Reset (arst high, at any time, including mid-debounce or mid-emission):**
  - All synchronizers, stb, counters, pend, gap_cnt, code, code_valid and overrun go to 0 immediately.
  - A raw line held high across reset release is seen as a 0->1 transition and produces one event after debounce.

## Timing
- Reset values: code = 000, code_valid = 0, overrun = 0.
- A raw rising edge captured at edge E0 reaches s2 at E1.
  - stb and pend update at E(DEBOUNCE_CYCLES).
  - With the scheduler idle, code is valid after E(DEBOUNCE_CYCLES+1).
  - Total latency is DEBOUNCE_CYCLES+1 edges from first capture.
- code is high for exactly one cycle per event.
- With back-to-back pending events, consecutive codes are separated by exactly max(GAP_CYCLES,1) cycles of 000. Defaults give pattern X,0,0,Y.
- The three channels are fully independent up to pend; simultaneous events on all three are emitted in the order cancel, 10, 5.
- No handshake: the downstream FSM samples code on every clk.

## Test plan
- **Reset state:** arst pulse at arbitrary times, including while code == 010.
  - code = 000, code_valid = 0 and overrun = 0 asynchronously.
  - No code for at least DEBOUNCE_CYCLES+1 edges after release with raw inputs low.
- **Clean coin (defaults):** coin5_raw high for 10 cycles starting before E0.
  - code = 001 for exactly the one cycle after E5; 000 everywhere else.
- **Bounce:** coin10_raw toggles 1,0,1,1,0,1,1,1,1,1 per cycle.
  - Exactly one code 010, emitted 5 edges after the final stable run begins.
  - No spurious codes.
- **Simultaneous events:** all three raw lines rise in the same cycle and stay high.
  - Codes emitted in order 101, 010, 001.
  - Each lasts one cycle with exactly 2 idle cycles between; overrun stays 0.
- **Overrun:** GAP_CYCLES = 15, DEBOUNCE_CYCLES = 1. Three coin10 pulses fire while a prior cancel holds off the scheduler.
  - One 010 is emitted; overrun = 1 and stays 1 until arst.
- **Reset mid-debounce:** cancel_raw high; arst asserted 2 cycles in and released while the line is still high.
  - Exactly one 101 appears, DEBOUNCE_CYCLES+1 edges after release.
